// File: rtl/phy_pkg.sv
// Constants shared by the PHY TX serializer and RX deserializer.
package phy_pkg;

  // Line characters
  localparam logic [7:0] COM_CHAR  = 8'hBC;
  localparam logic [7:0] IDLE_CHAR = 8'h7C;

  // RX alignment state encoding
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

endpackage

// File: rtl/phy_rx_deserializer.sv
// Bit-serial receiver: finds byte alignment from COM characters, then
// emits recovered data bytes with a one-cycle valid strobe.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [7:0]  COM        = COM_CHAR,
  parameter logic [7:0]  IDLE       = IDLE_CHAR,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       idle_out,
  output logic [3:0] sync_cnt
);

  localparam logic [3:0] SYNC_TGT = 4'(SYNC_COUNT);

  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic [1:0] state;
  logic       boundary;

  // Once aligned, the counter wraps to 7 exactly when sh holds a full byte
  always_comb begin
    boundary = (bit_cnt == 3'd7);
  end

  always_comb begin
    active = (state == ACTIVE);
  end

  // Shift window, bit counter and alignment FSM
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      sh        <= '0;
      bit_cnt   <= '0;
      state     <= SEARCH;
      sync_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      idle_out  <= 1'b0;
    end else begin
      sh        <= {sh[6:0], data_in};
      bit_cnt   <= bit_cnt + 3'd1;
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          if (sh == COM) begin
            state    <= ALIGN;
            sync_cnt <= 4'd1;
            bit_cnt  <= '0;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (sh == COM) begin
              sync_cnt <= sync_cnt + 4'd1;
              if (sync_cnt + 4'd1 == SYNC_TGT) begin
                state <= ACTIVE;
              end
            end else begin
              state    <= SEARCH;
              sync_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            if (sh == COM) begin
              if (sync_cnt != 4'd15) begin
                sync_cnt <= sync_cnt + 4'd1;
              end
            end else if (sh == IDLE) begin
              idle_out <= 1'b1;
            end else begin
              data_out  <= sh;
              valid_out <= 1'b1;
              idle_out  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          sync_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Self-checking bench for phy_rx_deserializer: table-driven scenarios,
// hand-written reset sequences and a randomized stream, all compared
// against a cycle-accurate reference model kept in this file.
module tb_phy_rx_deserializer;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       idle_out;
  logic [3:0] sync_cnt;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  phy_rx_deserializer #(.SYNC_COUNT(4)) dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .idle_out (idle_out),
    .sync_cnt (sync_cnt)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: keeps the received bit stream as an 8-bit window and
  // decides boundaries from absolute edge numbers relative to the lock anchor.
  int         m_edge = 0;
  int         m_anchor = 0;
  int         m_mode = 0;     // 0 hunting, 1 counting COMs, 2 locked
  int         m_cnt = 0;
  logic [7:0] m_win = '0;
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_idle = 1'b0;

  task automatic model_edge(input logic b, input logic rst_n);
    logic at_bnd;
    m_edge++;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_win = '0; m_data = '0;
      m_valid = 1'b0; m_idle = 1'b0;
      return;
    end
    m_valid = 1'b0;
    at_bnd = (m_mode != 0) && (((m_edge - m_anchor) % 8) == 0);
    if (m_mode == 0) begin
      if (m_win == 8'hBC) begin
        m_mode = 1; m_cnt = 1; m_anchor = m_edge;
      end
    end else if (m_mode == 1) begin
      if (at_bnd) begin
        if (m_win == 8'hBC) begin
          m_cnt++;
          if (m_cnt == 4) m_mode = 2;
        end else begin
          m_mode = 0; m_cnt = 0;
        end
      end
    end else if (at_bnd) begin
      if (m_win == 8'hBC) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else if (m_win == 8'h7C) m_idle = 1'b1;
      else begin
        m_data = m_win; m_valid = 1'b1; m_idle = 1'b0;
      end
    end
    m_win = {m_win[6:0], b};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One bit time: drive on the falling edge, model on the rising edge,
  // sample the DUT just after it.
  task automatic step(input logic b, input logic rst_n);
    @(negedge clk_32f);
    data_in = b;
    reset_L = rst_n;
    @(posedge clk_32f);
    model_edge(b, rst_n);
    #1;
    chk("cycle", {17'h0, data_out, valid_out, active, idle_out, sync_cnt},
        {17'h0, m_data, m_valid, (m_mode == 2), m_idle, 4'(m_cnt)});
    if (valid_out === 1'b1) pulses++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0);
  endtask

  typedef struct {
    string       name;
    int          njunk;
    logic [7:0]  junk;
    int          nbytes;
    logic [63:0] bytes;
    logic [7:0]  exp_data;
    int          exp_pulses;
    logic        exp_active;
    logic        exp_idle;
    logic [3:0]  exp_sync;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"lock",      0, 8'h00, 5, 64'hBCBCBCBCA5000000, 8'hA5, 1, 1'b1, 1'b0, 4'd4};
    vecs[1] = '{"misalign",  3, 8'h05, 5, 64'hBCBCBCBC3C000000, 8'h3C, 1, 1'b1, 1'b0, 4'd4};
    vecs[2] = '{"broken",    0, 8'h00, 8, 64'hBCBC00BCBCBCBC11, 8'h11, 1, 1'b1, 1'b0, 4'd4};
    vecs[3] = '{"interleave",0, 8'h00, 8, 64'hBCBCBCBC7C5A7CBC, 8'h5A, 1, 1'b1, 1'b1, 4'd5};
    vecs[4] = '{"no_lock",   0, 8'h00, 4, 64'hBCBCBC5500000000, 8'h00, 0, 1'b0, 1'b0, 4'd0};
    vecs[5] = '{"idle_end",  0, 8'h00, 5, 64'hBCBCBCBC7C000000, 8'h00, 0, 1'b1, 1'b1, 4'd4};

    // Reset held 10 cycles with a toggling input
    do_reset(10);
    chk("reset_outputs", {17'h0, data_out, valid_out, active, idle_out, sync_cnt}, 32'h0);

    // Table-driven scenarios
    foreach (vecs[k]) begin
      logic [63:0] bs;
      do_reset(2);
      pulses = 0;
      for (int i = vecs[k].njunk - 1; i >= 0; i--) step(vecs[k].junk[i], 1'b1);
      bs = vecs[k].bytes;
      for (int i = 0; i < vecs[k].nbytes; i++) send_byte(bs[63 - 8*i -: 8]);
      step(1'b0, 1'b1);
      chk({vecs[k].name, "_data"},   32'(data_out), 32'(vecs[k].exp_data));
      chk({vecs[k].name, "_pulses"}, 32'(pulses),   32'(vecs[k].exp_pulses));
      chk({vecs[k].name, "_active"}, 32'(active),   32'(vecs[k].exp_active));
      chk({vecs[k].name, "_idle"},   32'(idle_out), 32'(vecs[k].exp_idle));
      chk({vecs[k].name, "_sync"},   32'(sync_cnt), 32'(vecs[k].exp_sync));
    end

    // Interleave continued: trailing FF gives the second pulse
    do_reset(2);
    pulses = 0;
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h7C); send_byte(8'h5A); send_byte(8'h7C); send_byte(8'hBC); send_byte(8'hFF);
    step(1'b0, 1'b1);
    chk("interleave_ff_data", 32'(data_out), 32'hFF);
    chk("interleave_ff_pulses", 32'(pulses), 32'd2);
    chk("interleave_ff_idle", 32'(idle_out), 32'd0);

    // Reset during locked data traffic drops everything on that edge
    do_reset(2);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h66);
    for (int i = 7; i >= 4; i--) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("midreset_active", 32'(active), 32'd0);
    chk("midreset_data", 32'(data_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_byte(8'h42);
    step(1'b0, 1'b1);
    chk("relock_3com_active", 32'(active), 32'd0);
    chk("relock_3com_pulses", 32'(pulses), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h42);
    step(1'b0, 1'b1);
    chk("relock_4com_active", 32'(active), 32'd1);
    chk("relock_4com_data", 32'(data_out), 32'h42);
    chk("relock_4com_pulses", 32'(pulses), 32'd1);

    // Randomized traffic: COM/IDLE-heavy bytes, junk bit slips, rare resets
    do_reset(2);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset(1);
      else if (r < 7) begin
        int nj;
        nj = int'($urandom_range(1, 7));
        for (int j = 0; j < nj; j++) step(1'($urandom_range(0, 1)), 1'b1);
      end
      r = int'($urandom_range(0, 9));
      if (r < 4) send_byte(8'hBC);
      else if (r < 6) send_byte(8'h7C);
      else send_byte(8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
